// File: rtl/bmp_stream_parser_if.sv
// Stream-side bundle for bmp_stream_parser: the 32-bit file-word input and
// the pixel output. The environment takes the master modport and the parser
// takes the slave modport.
interface bmp_stream_parser_if #(
  parameter int unsigned DIM_W = 12
);
  logic [31:0]      DATA;
  logic             IN_VALID;
  logic             IN_READY;
  logic             PIX_READY;
  logic             PIX_VALID;
  logic [7:0]       PIX_R;
  logic [7:0]       PIX_G;
  logic [7:0]       PIX_B;
  logic [7:0]       PIX_GRAY;
  logic [DIM_W-1:0] PIX_X;
  logic [DIM_W-1:0] PIX_Y;
  logic             SOF;
  logic             EOL;
  logic             EOF;

  modport master (
    output DATA, IN_VALID, PIX_READY,
    input  IN_READY, PIX_VALID, PIX_R, PIX_G, PIX_B, PIX_GRAY,
           PIX_X, PIX_Y, SOF, EOL, EOF
  );

  modport slave (
    input  DATA, IN_VALID, PIX_READY,
    output IN_READY, PIX_VALID, PIX_R, PIX_G, PIX_B, PIX_GRAY,
           PIX_X, PIX_Y, SOF, EOL, EOF
  );
endinterface

// File: rtl/bmp_stream_parser.sv
// BMP front end: parses and validates the 54-byte header from a stream of
// little-endian 32-bit words, skips to the pixel array, strips row padding
// and emits one RGB pixel per cycle with raster coordinates and frame flags.
// Optional luma output is enabled by defining BMP_PARSER_GRAY_EN.
module bmp_stream_parser #(
  parameter int unsigned DIM_W = 12,
  parameter int unsigned OFF_W = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  bmp_stream_parser_if.slave bus,
  output logic [DIM_W-1:0]   WIDTH,
  output logic [DIM_W-1:0]   HEIGHT,
  output logic               HDR_VALID,
  output logic               ERR
);

  typedef enum logic [2:0] {
    S_HEADER, S_SKIP, S_PIXELS, S_PAD, S_FLUSH, S_DONE, S_ERROR
  } state_t;

  state_t state_q, state_d;

  // 8-byte shift buffer, oldest byte in [7:0]
  logic [63:0]      buf_q, buf_d;
  logic [3:0]       cnt_q, cnt_d, cnt_mid;
  logic [1:0]       cons_n;
  logic             issue, accept, store;

  logic [OFF_W-1:0] byte_cnt_q;
  logic [15:0]      sig_q, bpp_q;
  logic [31:0]      offset_q, width_f_q, height_f_q;
  logic [5:0]       hidx;
  logic [1:0]       lane;
  logic [7:0]       hbyte;
  logic             hdr_ok, hdr_last, skip_last, row_end, frame_row, pad_last, last_row;
  logic [1:0]       pad_q, pad_len;
  logic [DIM_W-1:0] x_q, y_q;

  logic             in_ready_q, pix_valid_q;
  logic [7:0]       r_q, g_q, b_q;
  logic [DIM_W-1:0] px_q, py_q;
  logic             sof_q, eol_q, eof_q;

  assign hbyte     = buf_q[7:0];
  assign hidx      = byte_cnt_q[5:0];
  // multi-byte fields start at 10, 18 and 22, all congruent to 2 mod 4
  assign lane      = hidx[1:0] - 2'd2;
  assign hdr_last  = (byte_cnt_q == OFF_W'(53));
  assign skip_last = (byte_cnt_q == (offset_q[OFF_W-1:0] - OFF_W'(1)));
  assign row_end   = (x_q == (WIDTH - DIM_W'(1)));
  assign frame_row = (y_q == (HEIGHT - DIM_W'(1)));
  assign pad_len   = WIDTH[1:0];
  assign pad_last  = (pad_q == (pad_len - 2'd1));
  // y has already advanced past the final row once its EOL pixel issued
  assign last_row  = (y_q == HEIGHT);

  assign hdr_ok = (sig_q == 16'h4D42) && (bpp_q == 16'd24) &&
                  (offset_q >= 32'd54) && ((offset_q >> OFF_W) == 32'd0) &&
                  (width_f_q != 32'd0) && ((width_f_q >> DIM_W) == 32'd0) &&
                  (height_f_q != 32'd0) && ((height_f_q >> DIM_W) == 32'd0);

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_HEADER;
    else if (ENABLE) state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HEADER: if (cons_n != 2'd0 && hdr_last)
                  state_d = !hdr_ok ? S_ERROR :
                            (offset_q == 32'd54) ? S_PIXELS : S_SKIP;
      S_SKIP:   if (cons_n != 2'd0 && skip_last) state_d = S_PIXELS;
      S_PIXELS: if (issue && row_end) begin
                  if (pad_len != 2'd0) state_d = S_PAD;
                  else if (frame_row) state_d = S_FLUSH;
                end
      S_PAD:    if (cons_n != 2'd0 && pad_last) state_d = last_row ? S_FLUSH : S_PIXELS;
      S_FLUSH:  if (!pix_valid_q || bus.PIX_READY) state_d = S_DONE;
      default:  ;
    endcase
  end

  // FSM outputs: byte consumption, pixel issue and post-consume buffer image
  always_comb begin
    cons_n = 2'd0;
    issue  = 1'b0;
    unique case (state_q)
      S_HEADER, S_SKIP, S_PAD: if (cnt_q != 4'd0) cons_n = 2'd1;
      S_PIXELS: if (cnt_q >= 4'd3 && (!pix_valid_q || bus.PIX_READY)) begin
                  cons_n = 2'd3;
                  issue  = 1'b1;
                end
      default: ;
    endcase
    accept  = ENABLE && bus.IN_VALID && in_ready_q;
    store   = accept && (state_q != S_ERROR);
    cnt_mid = cnt_q - {2'b00, cons_n};
    buf_d   = buf_q >> {cons_n, 3'b000};
    cnt_d   = cnt_mid;
    if (store) begin
      buf_d = buf_d | ({32'h0, bus.DATA} << {cnt_mid, 3'b000});
      cnt_d = cnt_mid + 4'd4;
    end
  end

  // Datapath: buffer, header fields, counters and the pixel output register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      byte_cnt_q  <= '0;
      sig_q       <= '0;
      bpp_q       <= '0;
      offset_q    <= '0;
      width_f_q   <= '0;
      height_f_q  <= '0;
      pad_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      WIDTH       <= '0;
      HEIGHT      <= '0;
      HDR_VALID   <= 1'b0;
      ERR         <= 1'b0;
      pix_valid_q <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      px_q        <= '0;
      py_q        <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else if (ENABLE) begin
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (state_d == S_ERROR) || ((state_d != S_DONE) && (cnt_d <= 4'd4));

      if ((state_q == S_HEADER || state_q == S_SKIP) && cons_n != 2'd0)
        byte_cnt_q <= byte_cnt_q + OFF_W'(1);

      if (state_q == S_HEADER && cons_n != 2'd0) begin
        if (hidx inside {6'd0, 6'd1})     sig_q[{hidx[0], 3'b000} +: 8]   <= hbyte;
        if (hidx inside {[6'd10:6'd13]})  offset_q[{lane, 3'b000} +: 8]   <= hbyte;
        if (hidx inside {[6'd18:6'd21]})  width_f_q[{lane, 3'b000} +: 8]  <= hbyte;
        if (hidx inside {[6'd22:6'd25]})  height_f_q[{lane, 3'b000} +: 8] <= hbyte;
        if (hidx inside {6'd28, 6'd29})   bpp_q[{hidx[0], 3'b000} +: 8]   <= hbyte;
      end

      if (state_q == S_HEADER && (state_d == S_SKIP || state_d == S_PIXELS)) begin
        WIDTH     <= width_f_q[DIM_W-1:0];
        HEIGHT    <= height_f_q[DIM_W-1:0];
        HDR_VALID <= 1'b1;
      end
      if (state_d == S_ERROR) ERR <= 1'b1;

      if (state_q == S_PAD && cons_n != 2'd0)
        pad_q <= pad_last ? 2'd0 : pad_q + 2'd1;

      if (issue) begin
        pix_valid_q <= 1'b1;
        r_q   <= buf_q[23:16];
        g_q   <= buf_q[15:8];
        b_q   <= buf_q[7:0];
        px_q  <= x_q;
        py_q  <= y_q;
        sof_q <= (x_q == '0) && (y_q == '0);
        eol_q <= row_end;
        eof_q <= row_end && frame_row;
        if (row_end) begin
          x_q <= '0;
          y_q <= y_q + DIM_W'(1);
        end else begin
          x_q <= x_q + DIM_W'(1);
        end
      end else if (pix_valid_q && bus.PIX_READY) begin
        pix_valid_q <= 1'b0;
        sof_q       <= 1'b0;
        eol_q       <= 1'b0;
        eof_q       <= 1'b0;
      end
    end
  end

`ifdef BMP_PARSER_GRAY_EN
  logic [15:0] gray_sum;
  logic [7:0]  gray_q;

  // Luma of the pixel about to issue, fixed-point weights summing to 256
  always_comb begin
    gray_sum = 16'd77 * {8'd0, buf_q[23:16]} + 16'd150 * {8'd0, buf_q[15:8]} +
               16'd29 * {8'd0, buf_q[7:0]};
  end

  // Luma register loads together with RGB
  always_ff @(posedge CLK) begin
    if (RESET) gray_q <= '0;
    else if (ENABLE && issue) gray_q <= 8'(gray_sum >> 8);
  end

  assign bus.PIX_GRAY = gray_q;
`else
  assign bus.PIX_GRAY = '0;
`endif

  assign bus.IN_READY  = in_ready_q && ENABLE;
  assign bus.PIX_VALID = pix_valid_q && ENABLE;
  assign bus.PIX_R     = r_q;
  assign bus.PIX_G     = g_q;
  assign bus.PIX_B     = b_q;
  assign bus.PIX_X     = px_q;
  assign bus.PIX_Y     = py_q;
  assign bus.SOF       = sof_q;
  assign bus.EOL       = eol_q;
  assign bus.EOF       = eof_q;

endmodule

// File: doc/bmp_stream_parser.md
Name: bmp_stream_parser

Overview:
- Front-end stage that feeds the detection pipeline in `top`.
- Consumes the raw BMP file as a stream of 32-bit little-endian words, parses and validates the header, skips to the pixel array, and strips row padding.
- Emits one 24-bit RGB pixel per cycle with raster coordinates and frame markers.
- Downstream stages only ever see clean pixels plus frame geometry.

Parameters:
- DIM_W, 12, width of WIDTH/HEIGHT/PIX_X/PIX_Y; maximum image dimension is 2^DIM_W-1.
- OFF_W, 16, width of the internal byte counter and the pixel-offset compare; offsets must be below 2^OFF_W.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  global advance; 0 freezes all state and deasserts IN_READY and PIX_VALID.
- DATA  in  32  file bytes; byte n+0 in [7:0] … byte n+3 in [31:24].
- IN_VALID  in  1  DATA valid.
- IN_READY  out  1  word accepted when IN_VALID & IN_READY & ENABLE.
- PIX_READY  in  1  downstream ready.
- PIX_VALID  out  1  pixel valid.
- PIX_R, PIX_G, PIX_B  out  8 each  pixel colour.
- PIX_X, PIX_Y  out  DIM_W each  column and file-order row of the current pixel.
- SOF, EOL, EOF  out  1 each  first pixel of frame, last pixel of row, last pixel of frame; qualified by PIX_VALID.
- PIX_GRAY  out  8  luma (optional feature).
- WIDTH, HEIGHT  out  DIM_W each  parsed dimensions.
- HDR_VALID  out  1  header accepted.
- ERR  out  1  sticky header error.

Behaviour:
- Synchronous, active-high reset, sampled on the CLK rising edge.
  - State → HEADER; byte counter and byte buffer cleared.
  - Outputs reset to 0: IN_READY, PIX_VALID, SOF, EOL, EOF, HDR_VALID, ERR, PIX_*, WIDTH, HEIGHT.
  - RESET mid-frame abandons the frame with no partial EOF.
- Byte buffer:
  - 8-byte shift buffer; a word is accepted only when ≥4 bytes are free.
  - IN_READY is registered, equal to (free ≥ 4 next cycle) and state ∉ {DONE}.
  - At most one word in and one consumption event (1 header byte, 1 skip byte, 1 pad byte, or 3 pixel bytes) per cycle.
- Header parse (state HEADER) consumes file bytes 0–53 one per cycle and latches:
  - sig (bytes 0–1), offset (bytes 10–13), width (bytes 18–21), height (bytes 22–25), bpp (bytes 28–29).
  - Byte-counter wrap beyond 2^OFF_W is impossible because offset < 2^OFF_W is checked.
- Header check after byte 53. All of the following must hold, else → ERR:
  - sig = 0x4D42;
  - bpp = 24;
  - 54 ≤ offset < 2^OFF_W;
  - 1 ≤ width < 2^DIM_W;
  - height signed > 0 and < 2^DIM_W.
- On a passing check: WIDTH/HEIGHT load, HDR_VALID=1 and held, → SKIP.
- SKIP: discard bytes until byte count = offset; if offset = 54, pass straight to PIXELS with no bubble.
- PIXELS:
  - Bytes arrive in B,G,R order; a pixel issues when ≥3 bytes are buffered and the output register is empty or being drained.
  - Output register is held while PIX_VALID & !PIX_READY.
  - Latency: first pixel PIX_VALID two cycles after the word holding its last byte is accepted, given no stall.
- Row handling:
  - X counts 0..WIDTH-1; EOL=1 at X=WIDTH-1.
  - After EOL, pad = WIDTH mod 4 bytes, consumed in PAD state, one byte per cycle; pad=0 skips PAD.
  - Y increments after each row.
  - SOF=1 at X=0, Y=0.
  - EOF=1 with EOL on Y=HEIGHT-1; after that pixel's handshake and that row's pad → DONE.
- DONE: IN_READY=0, outputs idle, HDR_VALID stays 1; only RESET leaves.
- ERR:
  - ERR=1 sticky, PIX_VALID=0, IN_READY=1; all input words are drained and dropped until RESET.
  - An error on any header field is reported only after byte 53, with a single timing.
- Simultaneous events:
  - Word acceptance and byte consumption in the same cycle are both honoured; free-space accounting uses the post-consume count.
  - ENABLE=0 overrides all handshakes.

Optional Feature:
- Macro: BMP_PARSER_GRAY_EN.
- When defined:
  - PIX_GRAY = (77·R + 150·G + 29·B) >> 8, computed in a 16-bit unsigned intermediate.
  - Registered alongside RGB with the same valid and latency.
- When undefined: PIX_GRAY is tied to 0, no multiplier logic is present, and all other behaviour is identical.

Test Plan:
- 4×2 image, offset 54, pixels BGR=(i,i+1,i+2) → 8 pixels RGB=(i+2,i+1,i), SOF on the first, EOL at X=3, EOF on (3,1), then DONE with IN_READY=0; WIDTH=4, HEIGHT=2, HDR_VALID=1.
- 3×2 image (3 pad bytes per row of 0xEE) → 6 pixels, no 0xEE ever seen on PIX_*, EOL at X=2 for Y=0 and Y=1.
- Signature 0x4D43 → ERR=1 after byte 53, PIX_VALID never rises, IN_READY stays 1, HDR_VALID=0.
- bpp=8 in a valid-signature header → ERR=1, same response as the bad-signature case; RESET then a valid stream → normal 4×2 result.
- Offset 58 with 4 junk bytes 0xAA, plus PIX_READY toggling 1-0-0-1 → junk skipped, each pixel held stable while PIX_READY=0, no pixel lost or duplicated.
- With BMP_PARSER_GRAY_EN: pixel R=G=B=200 → PIX_GRAY=200; R=255,G=0,B=0 → PIX_GRAY=76.
